// File: rtl/uart_pkg.sv
// uart_pkg: shared parity constants, TX/RX FSM encodings and the frame-length helper.
package uart_pkg;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_e;
    function automatic int frame_bits(input int dw, input int pm, input int sb);
        return 1 + dw + ((pm != PARITY_NONE) ? 1 : 0) + sb;
    endfunction
endpackage

// File: rtl/uart_core_param_if.sv
// uart_core_param_if: host-side word interface plus the pad-side serial lines of the UART core.
interface uart_core_param_if #(parameter int DATA_WIDTH = 8);
    logic                  loopback;
    logic                  enable;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_busy;
    logic                  serial_out;
    logic                  serial_in;
    logic [DATA_WIDTH-1:0] received_data;
    logic                  data_is_valid;
    logic                  parity_error;
    logic                  framing_error;
    modport slave (
        input  loopback, enable, i_data, serial_in,
        output o_busy, serial_out, received_data, data_is_valid, parity_error, framing_error
    );
    modport master (
        output loopback, enable, i_data, serial_in,
        input  o_busy, serial_out, received_data, data_is_valid, parity_error, framing_error
    );
endinterface

// File: rtl/uart_sync.sv
// uart_sync: NUM_SYNC-flop synchroniser for the asynchronous rx line, resetting to the idle-high level.
module uart_sync #(
    parameter int NUM_SYNC = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [NUM_SYNC-1:0] sync_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[NUM_SYNC-2:0], d_i};
    assign q_o = sync_q[NUM_SYNC-1];
endmodule

// File: rtl/uart_core_param.sv
// uart_core_param: full-duplex UART with parametrised frame format, runtime loopback,
// parity/framing error flags and start-bit glitch rejection.
module uart_core_param import uart_pkg::*; #(
    parameter int DATA_WIDTH     = 8,
    parameter int CLOCKS_PER_BIT = 8,
    parameter int PARITY_MODE    = 1,
    parameter int STOP_BITS      = 1,
    parameter int NUM_SYNC       = 3
) (
    input logic              clk,
    input logic              reset,
    uart_core_param_if.slave u
);
    localparam int            TW     = $clog2(CLOCKS_PER_BIT);
    localparam logic [TW-1:0] BIT_T  = TW'(CLOCKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_T = TW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    LAST_D = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]    LAST_S = 4'(STOP_BITS - 1);
    localparam logic          ODD    = PARITY_MODE == PARITY_ODD;
    localparam logic          HAS_P  = PARITY_MODE != PARITY_NONE;

    tx_state_e             tx_q, tx_d;
    logic [TW-1:0]         ttick_q, ttick_d;
    logic [3:0]            tidx_q, tidx_d;
    logic [DATA_WIDTH-1:0] tsh_q, tsh_d;
    logic                  tpar_q, tpar_d;
    logic                  tend, tx_line;

    rx_state_e             rx_q, rx_d;
    logic [TW-1:0]         rtick_q, rtick_d;
    logic [3:0]            ridx_q, ridx_d;
    logic [DATA_WIDTH-1:0] rsh_q, rsh_d, rdata_q, rdata_d;
    logic                  rpar_q, rpar_d, prev_q, rx_s, rend;
    logic                  valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;

    assign tend = ttick_q == '0;
    assign rend = rtick_q == '0;

    uart_sync #(.NUM_SYNC(NUM_SYNC)) u_sync (
        .clk(clk),
        .rst(reset),
        .d_i(u.loopback ? tx_line : u.serial_in),
        .q_o(rx_s)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            tx_q    <= TX_IDLE;
            ttick_q <= '0;
            tidx_q  <= '0;
            tsh_q   <= '0;
            tpar_q  <= 1'b0;
            rx_q    <= RX_IDLE;
            rtick_q <= '0;
            ridx_q  <= '0;
            rsh_q   <= '0;
            rpar_q  <= 1'b0;
            prev_q  <= 1'b1;
            rdata_q <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            tx_q    <= tx_d;
            ttick_q <= ttick_d;
            tidx_q  <= tidx_d;
            tsh_q   <= tsh_d;
            tpar_q  <= tpar_d;
            rx_q    <= rx_d;
            rtick_q <= rtick_d;
            ridx_q  <= ridx_d;
            rsh_q   <= rsh_d;
            rpar_q  <= rpar_d;
            prev_q  <= rx_s;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end

    // tidx counts data bits, then is reloaded to count stop periods
    always_comb begin
        tx_d    = tx_q;
        ttick_d = tend ? BIT_T : ttick_q - 1'b1;
        tidx_d  = tidx_q;
        tsh_d   = tsh_q;
        tpar_d  = tpar_q;
        case (tx_q)
            TX_IDLE: if (u.enable) begin
                tx_d    = TX_START;
                ttick_d = BIT_T;
                tsh_d   = u.i_data;
                tpar_d  = ^u.i_data ^ ODD;
            end
            TX_START: if (tend) begin
                tx_d   = TX_DATA;
                tidx_d = LAST_D;
            end
            TX_DATA: if (tend) begin
                tsh_d  = tsh_q >> 1;
                tidx_d = tidx_q == '0 ? LAST_S : tidx_q - 1'b1;
                tx_d   = tidx_q != '0 ? TX_DATA : HAS_P ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: if (tend) tx_d = TX_STOP;
            TX_STOP: if (tend) begin
                tidx_d = tidx_q - 1'b1;
                tx_d   = tidx_q == '0 ? TX_IDLE : TX_STOP;
            end
            default: tx_d = TX_IDLE;
        endcase
    end

    // only the first stop bit is sampled; a low stop holds off re-arming until the line idles
    always_comb begin
        rx_d    = rx_q;
        rtick_d = rend ? BIT_T : rtick_q - 1'b1;
        ridx_d  = ridx_q;
        rsh_d   = rsh_q;
        rpar_d  = rpar_q;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        case (rx_q)
            RX_IDLE: if (prev_q && !rx_s) begin
                rx_d    = RX_START;
                rtick_d = HALF_T;
            end
            RX_START: if (rend) begin
                rx_d   = rx_s ? RX_IDLE : RX_DATA;
                ridx_d = LAST_D;
            end
            RX_DATA: if (rend) begin
                rsh_d  = {rx_s, rsh_q[DATA_WIDTH-1:1]};
                ridx_d = ridx_q - 1'b1;
                rx_d   = ridx_q != '0 ? RX_DATA : HAS_P ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (rend) begin
                rpar_d = rx_s;
                rx_d   = RX_STOP;
            end
            RX_STOP: if (rend) begin
                rdata_d = rsh_q;
                valid_d = 1'b1;
                perr_d  = HAS_P && (rpar_q != (^rsh_q ^ ODD));
                ferr_d  = !rx_s;
                rx_d    = rx_s ? RX_IDLE : RX_BREAK;
            end
            RX_BREAK: if (rx_s) rx_d = RX_IDLE;
            default: rx_d = RX_IDLE;
        endcase
    end

    assign tx_line = tx_q == TX_START ? 1'b0 : tx_q == TX_DATA ? tsh_q[0] : tx_q == TX_PARITY ? tpar_q : 1'b1;
    assign u.serial_out    = tx_line;
    assign u.o_busy        = tx_q != TX_IDLE;
    assign u.received_data = rdata_q;
    assign u.data_is_valid = valid_q;
    assign u.parity_error  = perr_q;
    assign u.framing_error = ferr_q;
endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param: table-driven and randomized frame checks of two UART configurations
// against a frame-level reference model, plus rx error, glitch and reset corner sequences.
module tb_uart_core_param;
    import uart_pkg::*;
    localparam int CPB = 8;

    typedef struct {
        logic [8:0]  data;
        logic [15:0] frame;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_core_param_if #(.DATA_WIDTH(8)) ifa ();
    uart_core_param_if #(.DATA_WIDTH(7)) ifb ();

    uart_core_param #(.DATA_WIDTH(8), .CLOCKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1), .NUM_SYNC(3)) dut_a (
        .clk(clk), .reset(reset), .u(ifa)
    );
    uart_core_param #(.DATA_WIDTH(7), .CLOCKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(2), .NUM_SYNC(3)) dut_b (
        .clk(clk), .reset(reset), .u(ifb)
    );

    int checks = 0;
    int failures = 0;
    int sa_n = 0, sb_n = 0, leak = 0;
    logic [8:0] sa_d = '0, sb_d = '0;
    logic sa_pe = 1'b0, sa_fe = 1'b0, sb_pe = 1'b0, sb_fe = 1'b0;

    // strobe recorder; error flags seen outside a strobe count as leaks
    always @(negedge clk) begin
        if (ifa.data_is_valid) begin
            sa_n  <= sa_n + 1;
            sa_d  <= {1'b0, ifa.received_data};
            sa_pe <= ifa.parity_error;
            sa_fe <= ifa.framing_error;
        end else if (ifa.parity_error || ifa.framing_error) leak <= leak + 1;
        if (ifb.data_is_valid) begin
            sb_n  <= sb_n + 1;
            sb_d  <= {2'b0, ifb.received_data};
            sb_pe <= ifb.parity_error;
            sb_fe <= ifb.framing_error;
        end else if (ifb.parity_error || ifb.framing_error) leak <= leak + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // frame as a bit vector, bit 0 is the start bit
    function automatic logic [15:0] frame_model(input logic [8:0] d, input int dw, input int pm, input int sb);
        logic [15:0] f = '0;
        logic p = 1'b0;
        int nb = frame_bits(dw, pm, sb);
        for (int i = 0; i < dw; i++) begin
            f[1+i] = d[i];
            p ^= d[i];
        end
        if (pm != PARITY_NONE) f[1+dw] = (pm == PARITY_ODD) ? !p : p;
        for (int i = 0; i < sb; i++) f[nb-sb+i] = 1'b1;
        return f;
    endfunction

    task automatic drive(input bit b, input logic e, input logic [8:0] d);
        if (b) begin
            ifb.enable = e;
            ifb.i_data = d[6:0];
        end else begin
            ifa.enable = e;
            ifa.i_data = d[7:0];
        end
    endtask

    // one loopback frame: junk enable/i_data while busy must not disturb it
    task automatic tx_frame(input bit b, input logic [8:0] d, input logic [15:0] exp, input string tag);
        int dw = b ? 7 : 8;
        int nb = frame_bits(dw, b ? 2 : 1, b ? 2 : 1);
        int busy_n = 0;
        int n0 = b ? sb_n : sa_n;
        logic [15:0] seen = '0;
        logic [8:0] mask = b ? 9'h07f : 9'h0ff;
        @(negedge clk);
        drive(b, 1'b1, d);
        for (int k = 0; k < nb * CPB + 40; k++) begin
            @(negedge clk);
            drive(b, k >= 10 && k < 20, 9'($urandom));
            if (b ? ifb.o_busy : ifa.o_busy) busy_n++;
            if (k % CPB == CPB / 2 && k / CPB < nb) seen[k/CPB] = b ? ifb.serial_out : ifa.serial_out;
        end
        drive(b, 1'b0, '0);
        check({tag, " busy_cycles"}, busy_n, nb * CPB);
        check({tag, " line_bits"}, seen, exp);
        check({tag, " strobes"}, (b ? sb_n : sa_n) - n0, 1);
        check({tag, " rx_data"}, b ? sb_d : sa_d, d & mask);
        check({tag, " rx_errs"}, b ? {sb_pe, sb_fe} : {sa_pe, sa_fe}, 0);
    endtask

    task automatic rx_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ifa.serial_in = bits[i];
            repeat (CPB) @(negedge clk);
        end
        ifa.serial_in = 1'b1;
        repeat (3 * CPB) @(negedge clk);
    endtask

    initial begin
        vec_t tbl [9];
        vec_t tblb [4];
        int n0;
        logic [8:0] d;
        ifa.loopback = 1'b1; ifa.enable = 1'b0; ifa.i_data = '0; ifa.serial_in = 1'b1;
        ifb.loopback = 1'b1; ifb.enable = 1'b0; ifb.i_data = '0; ifb.serial_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst serial_out", ifa.serial_out, 1);
        check("rst busy", ifa.o_busy, 0);
        check("rst valid", ifa.data_is_valid, 0);
        check("rst rx_data", ifa.received_data, 0);
        check("rst errs", {ifa.parity_error, ifa.framing_error}, 0);
        check("rst b line/busy", {ifb.serial_out, ifb.o_busy}, 2'b10);
        reset = 1'b0;

        tbl[0] = '{data: 9'h0A5, frame: 16'h054A};
        tbl[1] = '{data: 9'h000, frame: 16'h0400};
        tbl[2] = '{data: 9'h0FF, frame: 16'h05FE};
        tbl[3] = '{data: 9'h001, frame: 16'h0602};
        for (int i = 4; i < 9; i++) begin
            d = 9'($urandom_range(0, 255));
            tbl[i] = '{data: d, frame: frame_model(d, 8, PARITY_EVEN, 1)};
        end
        for (int i = 0; i < 9; i++) tx_frame(1'b0, tbl[i].data, tbl[i].frame, $sformatf("a%0d", i));

        tblb[0] = '{data: 9'h03C, frame: 16'h0778};
        for (int i = 1; i < 4; i++) begin
            d = 9'($urandom_range(0, 127));
            tblb[i] = '{data: d, frame: frame_model(d, 7, PARITY_ODD, 2)};
        end
        for (int i = 0; i < 4; i++) tx_frame(1'b1, tblb[i].data, tblb[i].frame, $sformatf("b%0d", i));

        ifa.loopback = 1'b0;
        n0 = sa_n;
        rx_bits(frame_model(9'h05A, 8, PARITY_EVEN, 1) ^ 16'h0200, 11);
        check("perr strobes", sa_n - n0, 1);
        check("perr data", sa_d, 9'h05A);
        check("perr flags", {sa_pe, sa_fe}, 2'b10);

        n0 = sa_n;
        ifa.serial_in = 1'b0;
        repeat (15 * CPB) @(negedge clk);
        check("ferr strobes", sa_n - n0, 1);
        check("ferr data", sa_d, 9'h000);
        check("ferr flags", {sa_pe, sa_fe}, 2'b01);
        ifa.serial_in = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n0 = sa_n;
        rx_bits(frame_model(9'h03C, 8, PARITY_EVEN, 1), 11);
        check("post-ferr frame", {sa_n - n0, sa_d, sa_pe, sa_fe}, {32'd1, 9'h03C, 2'b00});

        n0 = sa_n;
        ifa.serial_in = 1'b0;
        repeat (2) @(negedge clk);
        ifa.serial_in = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("glitch no strobe", sa_n - n0, 0);
        rx_bits(frame_model(9'h081, 8, PARITY_EVEN, 1), 11);
        check("post-glitch frame", {sa_n - n0, sa_d, sa_pe, sa_fe}, {32'd1, 9'h081, 2'b00});

        ifa.loopback = 1'b1;
        n0 = sa_n;
        @(negedge clk);
        drive(1'b0, 1'b1, 9'h033);
        @(negedge clk);
        drive(1'b0, 1'b0, 9'h000);
        repeat (30) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst line/busy", {ifa.serial_out, ifa.o_busy}, 2'b10);
        @(negedge clk);
        reset = 1'b0;
        repeat (150) @(negedge clk);
        check("midrst no strobe", sa_n - n0, 0);
        tx_frame(1'b0, 9'h0FF, 16'h05FE, "after_rst");

        check("err leak", leak, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
- Full-duplex UART transmitter plus receiver, parametrised in data width, parity mode, stop-bit count and baud divisor.
- Adds runtime loopback, separate parity/framing error flags, and start-bit glitch rejection.
- Sits between the byte-level host logic and the pad pins; the internal loopback replaces external tx-to-rx wiring for self-test.

Parameters:
- DATA_WIDTH, 8: data bits per frame, legal 5..9.
- CLOCKS_PER_BIT, 8: clk cycles per bit, even, >=4.
- PARITY_MODE, 1: 0 none, 1 even, 2 odd.
- STOP_BITS, 1: 1 or 2.
- NUM_SYNC, 3: rx synchroniser flops, >=2.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- loopback  in  1  1: rx samples internal serial_out; 0: rx samples serial_in.
- enable  in  1  tx request; accepted only when o_busy==0.
- i_data  in  DATA_WIDTH  tx word, captured on acceptance.
- o_busy  out  1  tx frame in progress.
- serial_out  out  1  tx line, idle high.
- serial_in  in  1  asynchronous rx line.
- received_data  out  DATA_WIDTH  last received word.
- data_is_valid  out  1  one-cycle strobe, new word present.
- parity_error  out  1  qualifies data_is_valid.
- framing_error  out  1  qualifies data_is_valid.

Behaviour:
- Reset values: serial_out=1; o_busy, data_is_valid, parity_error, framing_error =0; received_data=0; synchroniser flops=1; both FSMs IDLE.
- Frame: start(0), data LSB first, optional parity, STOP_BITS x 1. FRAME_BITS = 1+DATA_WIDTH+(PARITY_MODE!=0)+STOP_BITS.
- Parity: even -> parity bit = XOR(data); odd -> ~XOR(data).
- TX acceptance: cycle N with enable=1 and o_busy=0 latches i_data; o_busy=1 from N+1.
- TX timing: serial_out=0 from N+1 for CLOCKS_PER_BIT cycles; each bit is held exactly CLOCKS_PER_BIT cycles.
- TX completion: o_busy drops on the cycle after the last stop bit ends, so it is high for FRAME_BITS*CLOCKS_PER_BIT cycles.
- TX ignores enable while busy; i_data changes after acceptance have no effect.
- TX FSM: IDLE -> START -> DATA (bit index 0..DATA_WIDTH-1) -> PARITY (skipped if none) -> STOP (STOP_BITS periods) -> IDLE. One down-counter for bit timing, one for bit index.
- RX input: mux(loopback), then NUM_SYNC flops. Start detect is a 1->0 transition on the synchronised line while in IDLE.
- RX start check: after CLOCKS_PER_BIT/2 cycles, sample the line. If it is high, treat as a glitch: return to IDLE with no strobe and no error.
- RX sampling: each later bit is sampled every CLOCKS_PER_BIT cycles (mid-bit). Only the first stop bit is checked.
- RX FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
- RX result: at the first stop-bit sample, received_data is updated and data_is_valid pulses for one cycle.
  - parity_error = parity mismatch.
  - framing_error = stop sample low.
  - Both error flags are valid only during the strobe and are 0 otherwise.
- RX return to IDLE:
  - Good frame: IDLE on the cycle after the strobe.
  - Framing error: wait for line high before re-arming.
- Loopback latency: strobe occurs NUM_SYNC + (FRAME_BITS - STOP_BITS)*CLOCKS_PER_BIT + CLOCKS_PER_BIT/2 cycles after serial_out first goes low, +/-1.
- Reset mid-frame: serial_out returns high immediately (asynchronous); no strobe is produced for the partial frame.
- Toggling loopback mid-frame is allowed but not guaranteed to produce a valid frame.
- TX and RX are fully independent; simultaneous tx acceptance and rx strobe are legal.

Decomposition:
- Package uart_pkg: PARITY_NONE/EVEN/ODD constants, TX/RX state encodings, frame_bits function.
- Sub-module uart_sync: NUM_SYNC-flop synchroniser, reset value 1.
- TX and RX FSMs remain in this module.

Test Plan:
- Defaults, loopback=1, i_data=8'hA5 pulsed once -> o_busy high exactly 88 cycles; serial_out sequence 0,1,0,1,0,0,1,0,1,0,1; one strobe with received_data=8'hA5, both errors 0.
- PARITY_MODE=2, DATA_WIDTH=7, STOP_BITS=2, loopback=1, i_data=7'h3C -> parity bit 1; o_busy 88 cycles; strobe with 7'h3C, no errors.
- loopback=0, drive serial_in frame 0x5A with parity bit inverted -> strobe with received_data=8'h5A, parity_error=1.
- loopback=0, frame 0x00 with stop bit 0 -> strobe with framing_error=1; no new start detected until serial_in high again.
- loopback=0, serial_in low 2 cycles then high -> no strobe; FSM back in IDLE; a following valid 0x81 frame is received correctly.
- reset asserted mid-data-bit of a tx frame -> serial_out=1 and o_busy=0 same cycle; no strobe; next enable with 0xFF completes normally.
